// File: rtl/rll_key_manager.sv
// rll_key_manager: serial key loader plus XOR/XNOR key-gate layer for an RLL-locked datapath.
//   The key arrives one bit per cycle, LSB first. It is checked on commit and then held in
//   the active key register. That register drives a key-gate layer that sits on a
//   single-stage valid/ready register slice.
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   key_sin, key_sin_valid      serial key bit and its strobe
//   key_commit, key_clear       copy the full shift register into the active key / wipe all key state
//   key_busy, key_loaded        shifting in progress / active key valid
//   key_err, key_count          sticky protocol error / number of bits shifted so far
//   in_valid, in_ready, in_data       upstream beat (in_ready is combinational)
//   out_valid, out_ready, out_data    downstream beat, held until it is taken
module rll_key_manager #(
    parameter int unsigned      KEY_W    = 16,
    parameter int unsigned      DATA_W   = 32,
    parameter logic [KEY_W-1:0] GATE_POL = KEY_W'(16'hA5C3),
    parameter bit               GATE_OFF = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_sin,
    input  logic                         key_sin_valid,
    input  logic                         key_commit,
    input  logic                         key_clear,
    output logic                         key_busy,
    output logic                         key_loaded,
    output logic                         key_err,
    output logic [$clog2(KEY_W+1)-1:0]   key_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   shift_reg;
    logic [KEY_W-1:0]   active_key;
    logic [DATA_W-1:0]  gate_mask_c;
    logic [DATA_W-1:0]  gated_c;
    logic               accept_c;

    // Key load FSM. Bits enter at the MSB end and move right, so after KEY_W bits
    // the first bit received sits at bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            active_key <= '0;
            key_count  <= '0;
            key_loaded <= 1'b0;
            key_err    <= 1'b0;
            key_busy   <= 1'b0;
        end else if (key_clear) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            active_key <= '0;
            key_count  <= '0;
            key_loaded <= 1'b0;
            key_err    <= 1'b0;
            key_busy   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (key_commit) begin
                        key_err <= 1'b1;
                    end
                    if (key_sin_valid) begin
                        shift_reg <= (shift_reg >> 1) | (KEY_W'(key_sin) << (KEY_W - 1));
                        key_count <= key_count + CNT_W'(1);
                        if (key_count == CNT_LAST) begin
                            state    <= ST_FULL;
                            key_busy <= 1'b0;
                        end else begin
                            state    <= ST_SHIFT;
                            key_busy <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Extra bits are dropped; they never reach the shift register.
                    if (key_sin_valid) begin
                        key_err <= 1'b1;
                    end
                    if (key_commit) begin
                        active_key <= shift_reg;
                        key_loaded <= 1'b1;
                        key_count  <= '0;
                        state      <= ST_IDLE;
                        key_busy   <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

    // Key-gate layer. A gate bit is inverting unless the key bit equals its polarity bit.
    // Bits at and above KEY_W have a zero mask, so they pass through unchanged.
    always_comb begin
        gate_mask_c = DATA_W'(active_key ^ GATE_POL);
        gated_c     = in_data ^ gate_mask_c;
        if (GATE_OFF && !key_loaded) begin
            gated_c = '0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Single register slice. out_data changes only on an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            out_data  <= gated_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rll_key_manager.sv
// Testbench for rll_key_manager with default parameters (KEY_W=16, DATA_W=32, GATE_OFF=1).
module tb_rll_key_manager;

    localparam int unsigned KEY_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(KEY_W + 1);
    localparam logic [15:0] POL    = 16'hA5C3;

    logic              clk;
    logic              rst_n;
    logic              key_sin;
    logic              key_sin_valid;
    logic              key_commit;
    logic              key_clear;
    logic              key_busy;
    logic              key_loaded;
    logic              key_err;
    logic [CNT_W-1:0]  key_count;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: received key bits, the committed key, and the held output beat.
    bit          kq[$];
    logic [15:0] m_key    = '0;
    bit          m_loaded = 0;
    bit          m_err    = 0;
    bit          m_ov     = 0;
    logic [31:0] m_od     = '0;

    rll_key_manager #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .GATE_POL(16'hA5C3), .GATE_OFF(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_sin(key_sin), .key_sin_valid(key_sin_valid),
        .key_commit(key_commit), .key_clear(key_clear),
        .key_busy(key_busy), .key_loaded(key_loaded), .key_err(key_err), .key_count(key_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model_gate(input logic [31:0] d);
        if (!m_loaded) return 32'h0;
        return d ^ {16'h0, m_key ^ POL};
    endfunction

    // Advance the model by one clock edge using the inputs driven before that edge.
    function automatic void model_edge();
        int   sz;
        bit   acc;
        logic [15:0] k;
        if (!rst_n) begin
            kq.delete();
            m_key = '0; m_loaded = 0; m_err = 0; m_ov = 0; m_od = '0;
            return;
        end
        acc = in_valid && (!m_ov || out_ready);
        if (acc) begin
            m_od = model_gate(in_data);
            m_ov = 1;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (key_clear) begin
            kq.delete();
            m_key = '0; m_loaded = 0; m_err = 0;
            return;
        end
        sz = kq.size();
        if (key_sin_valid) begin
            if (sz < KEY_W) kq.push_back(key_sin);
            else m_err = 1;
        end
        if (key_commit) begin
            if (sz == KEY_W) begin
                k = '0;
                for (int i = 0; i < KEY_W; i++) if (kq[i]) k = k | (16'h1 << i);
                m_key = k;
                m_loaded = 1;
                kq.delete();
            end else begin
                m_err = 1;
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        key_sin = 0; key_sin_valid = 0; key_commit = 0; key_clear = 0;
        in_valid = 0; in_data = '0; out_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic shift_key(input logic [15:0] val, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            key_sin_valid = 1;
            key_sin = val[i];
            cycle();
        end
        key_sin_valid = 0;
        key_sin = 0;
    endtask

    task automatic load_key(input logic [15:0] val);
        shift_key(val, 16);
        key_commit = 1;
        cycle();
        key_commit = 0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        in_valid = 1;
        in_data = d;
        cycle();
        in_valid = 0;
    endtask

    task automatic test_reset();
        key_sin = 1; key_sin_valid = 1; key_commit = 1; key_clear = 0;
        in_valid = 1; in_data = 32'hDEAD_BEEF; out_ready = 0;
        rst_n = 0;
        cycle();
        n_vec++;
        if ({key_busy, key_loaded, key_err, out_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got busy/loaded/err/ov=%b exp=0000",
                     {key_busy, key_loaded, key_err, out_valid});
        end
        n_vec++;
        if (key_count !== CNT_W'(0) || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_count_data got count=%0d data=%h exp 0/0", key_count, out_data);
        end
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_correct_key();
        do_reset();
        load_key(16'hA5C3);
        n_vec++;
        if (key_loaded !== 1'b1 || key_err !== 1'b0 || key_count !== CNT_W'(0)) begin
            n_err++;
            $display("FAIL correct_key_state got loaded=%b err=%b count=%0d exp 1/0/0",
                     key_loaded, key_err, key_count);
        end
        send_beat(32'h1234_5678);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL correct_key_out got v=%b d=%h exp v=1 d=12345678", out_valid, out_data);
        end
    endtask

    task automatic test_zero_key();
        do_reset();
        load_key(16'h0000);
        send_beat(32'h0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_A5C3) begin
            n_err++;
            $display("FAIL zero_key_out got v=%b d=%h exp v=1 d=0000a5c3", out_valid, out_data);
        end
    endtask

    task automatic test_no_key();
        do_reset();
        send_beat(32'hFFFF_FFFF);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL no_key_out got v=%b d=%h exp v=1 d=00000000", out_valid, out_data);
        end
    endtask

    task automatic test_errors();
        do_reset();
        load_key(16'hA5C3);
        shift_key(16'h03FF, 10);
        n_vec++;
        if (key_count !== CNT_W'(10) || key_busy !== 1'b1 || key_err !== 1'b0) begin
            n_err++;
            $display("FAIL partial_shift got count=%0d busy=%b err=%b exp 10/1/0",
                     key_count, key_busy, key_err);
        end
        key_commit = 1;
        cycle();
        key_commit = 0;
        n_vec++;
        if (key_err !== 1'b1 || key_loaded !== 1'b1 || key_count !== CNT_W'(10)) begin
            n_err++;
            $display("FAIL early_commit got err=%b loaded=%b count=%0d exp 1/1/10",
                     key_err, key_loaded, key_count);
        end
        send_beat(32'hCAFE_F00D);
        n_vec++;
        if (out_data !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL early_commit_key_kept got d=%h exp cafef00d", out_data);
        end
        shift_key(16'h0000, 6);
        n_vec++;
        if (key_count !== CNT_W'(16) || key_busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_state got count=%0d busy=%b exp 16/0", key_count, key_busy);
        end
        shift_key(16'h0001, 1);
        n_vec++;
        if (key_count !== CNT_W'(16) || key_err !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_bit got count=%0d err=%b exp 16/1", key_count, key_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic [31:0] exp_q[$];
        int next;
        int got;
        int budget;
        do_reset();
        load_key(16'hA5C3);
        base = $urandom;
        out_ready = 0;
        in_valid = 1;
        in_data = base;
        cycle();
        exp_q.push_back(base);
        next = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = base + 32'(next);
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== base) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h",
                         i, in_ready, out_valid, out_data, base);
            end
            cycle();
        end
        got = 0;
        budget = 0;
        while ((next < 9 || exp_q.size() != 0) && budget < 200) begin
            in_valid = (next < 9);
            in_data = base + 32'(next);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL order beat=%0d got d=%h exp=%h", got, out_data,
                             (exp_q.size() != 0) ? exp_q[0] : 32'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(base + 32'(next));
                next++;
            end
            cycle();
            budget++;
        end
        n_vec++;
        if (got != 9) begin
            n_err++;
            $display("FAIL beat_count got=%0d exp=9 (budget=%0d)", got, budget);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_clear_commit();
        do_reset();
        load_key(16'hA5C3);
        shift_key(16'($urandom), 16);
        key_clear = 1;
        key_commit = 1;
        cycle();
        key_clear = 0;
        key_commit = 0;
        n_vec++;
        if (key_loaded !== 1'b0 || key_count !== CNT_W'(0) || key_err !== 1'b0 || key_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_commit got loaded=%b count=%0d err=%b busy=%b exp 0/0/0/0",
                     key_loaded, key_count, key_err, key_busy);
        end
        shift_key(16'h001F, 5);
        out_ready = 0;
        send_beat(32'h5555_AAAA);
        n_vec++;
        if (key_busy !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got busy=%b v=%b exp 1/1", key_busy, out_valid);
        end
        rst_n = 0;
        cycle();
        n_vec++;
        if ({key_busy, key_loaded, key_err, out_valid} !== 4'b0000 ||
            key_count !== CNT_W'(0) || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset got busy/loaded/err/ov=%b count=%0d d=%h exp 0000/0/0",
                     {key_busy, key_loaded, key_err, out_valid}, key_count, out_data);
        end
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        int sz;
        for (int c = 0; c < 3000; c++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            key_sin       = 1'($urandom);
            key_sin_valid = ($urandom_range(0, 9) < 6);
            key_commit    = ($urandom_range(0, 11) == 0);
            key_clear     = ($urandom_range(0, 79) == 0);
            in_valid      = 1'($urandom);
            in_data       = $urandom;
            out_ready     = ($urandom_range(0, 9) < 7);
            #1;
            sz = kq.size();
            n_vec++;
            if (key_loaded !== m_loaded || key_err !== m_err || key_count !== CNT_W'(sz) ||
                key_busy !== (sz > 0 && sz < KEY_W)) begin
                n_err++;
                $display("FAIL rand_key cyc=%0d got l/e/b=%b%b%b cnt=%0d exp %b%b%b cnt=%0d",
                         c, key_loaded, key_err, key_busy, key_count,
                         m_loaded, m_err, (sz > 0 && sz < KEY_W), sz);
            end
            n_vec++;
            if (out_valid !== m_ov || in_ready !== (!m_ov || out_ready) ||
                (m_ov && out_data !== m_od)) begin
                n_err++;
                $display("FAIL rand_data cyc=%0d got v=%b rdy=%b d=%h exp v=%b d=%h",
                         c, out_valid, in_ready, out_data, m_ov, m_od);
            end
            cycle();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_correct_key();
        test_zero_key();
        test_no_key();
        test_errors();
        test_back_to_back();
        test_clear_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
